// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per cycle, result held with isDone.
// Define SIGNED_DIV_EN for two's-complement operands; the default build divides unsigned.
module divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             isDone,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {IDLE, INIT, BIT, FIX, DONE} state_t;

  state_t state, nextState;

  logic [WIDTH:0]   remReg;
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] divMag;
  logic [CW-1:0]    count;
  logic             negQ;
  logic             negR;

  logic             dividendNeg;
  logic             divisorNeg;
  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   divExt;
  logic [WIDTH:0]   diff;
  logic             canSub;
  logic [WIDTH-1:0] qOut;
  logic [WIDTH-1:0] rOut;

`ifdef SIGNED_DIV_EN
  assign dividendNeg = dividend[WIDTH-1];
  assign divisorNeg  = divisor[WIDTH-1];
`else
  assign dividendNeg = 1'b0;
  assign divisorNeg  = 1'b0;
`endif

  // Magnitude of the most negative value wraps to itself, which is still correct read as unsigned.
  assign dividendMag = dividendNeg ? (~dividend + ONE) : dividend;
  assign divisorMag  = divisorNeg  ? (~divisor  + ONE) : divisor;

  assign shifted = {remReg[WIDTH-1:0], qReg[WIDTH-1]};
  assign divExt  = {1'b0, divMag};
  assign canSub  = (shifted >= divExt);
  assign diff    = shifted - divExt;

  assign qOut = negQ ? (~qReg + ONE) : qReg;
  assign rOut = negR ? (~remReg[WIDTH-1:0] + ONE) : remReg[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    isDone    = 1'b0;
    case (state)
      IDLE: begin
        isDone = 1'b1;
        if (start) nextState = INIT;
      end
      INIT: begin
        if (divisor == '0) nextState = DONE;
        else               nextState = BIT;
      end
      BIT: begin
        if (count == LAST_BIT) nextState = FIX;
      end
      FIX: begin
        nextState = DONE;
      end
      DONE: begin
        isDone = 1'b1;
        if (!start) nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Datapath: qReg starts as the dividend magnitude and is shifted out MSB-first as quotient bits enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      remReg    <= '0;
      qReg      <= '0;
      divMag    <= '0;
      count     <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          negQ   <= dividendNeg ^ divisorNeg;
          negR   <= dividendNeg;
          divMag <= divisorMag;
          qReg   <= dividendMag;
          remReg <= '0;
          count  <= '0;
          if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend;
            divByZero <= 1'b1;
          end
        end
        BIT: begin
          remReg <= canSub ? diff : shifted;
          qReg   <= {qReg[WIDTH-2:0], canSub};
          count  <= count + CW'(1);
        end
        FIX: begin
          quotient  <= qOut;
          remainder <= rOut;
          divByZero <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: driver queues model results, a monitor checks each completion.
// Follows SIGNED_DIV_EN to choose signed or unsigned reference arithmetic.
module tb_divider_seq;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         isDone;
  logic         divByZero;

  int   errors = 0;
  int   checks = 0;
  bit   ignoreNext = 1'b0;
  logic prevDone = 1'b1;
  exp_t last = '0;
  exp_t monE;
  exp_t expQ[$];

  divider_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .isDone(isDone),
    .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: language division truncates toward zero and % follows the dividend sign.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, qi, ri;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef SIGNED_DIV_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'(a);
      sb = longint'(b);
`endif
      qi = sa / sb;
      ri = sa % sb;
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (isDone === 1'b1 && prevDone === 1'b0) begin
        if (ignoreNext) begin
          ignoreNext = 1'b0;
        end else if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got completion expected none");
        end else begin
          monE = expQ.pop_front();
          checkOutput("quotient", quotient, monE.q);
          checkOutput("remainder", remainder, monE.r);
          checkOutput("divByZero", divByZero, monE.z);
        end
      end
      prevDone = isDone;
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit dropStart, input int hold);
    exp_t e;
    int   cyc;
    int   lat;
    e = model(a, b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    expQ.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && dropStart) start = 1'b0;
      if (cyc == 2) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (cyc == 4 && b != '0) checkOutput("held_prev_quotient", quotient, last.q);
    end while (isDone !== 1'b1 && cyc < 40);
    lat = (b == '0) ? 1 : W + 2;
    checkOutput("latency", cyc - 1, lat);
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold_isDone", isDone, 1);
      checkOutput("hold_quotient", quotient, e.q);
      checkOutput("hold_remainder", remainder, e.r);
    end
    start = 1'b0;
    last  = e;
  endtask

  task automatic applyReset();
    @(negedge clk);
    dividend = 8'd201;
    divisor  = 8'd9;
    start    = 1'b1;
    repeat (4) @(negedge clk);
    rst        = 1'b1;
    start      = 1'b0;
    ignoreNext = 1'b1;
    @(negedge clk);
    checkOutput("rst_isDone", isDone, 1);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    checkOutput("rst_divByZero", divByZero, 0);
    rst  = 1'b0;
    last = '0;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    repeat (2) @(negedge clk);
    checkOutput("reset_isDone", isDone, 1);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_divByZero", divByZero, 0);
    rst = 1'b0;

    applyStimulus(8'd100, 8'd7, 1'b0, 5);
    applyStimulus(8'h9C, 8'd7, 1'b0, 0);
    applyStimulus(8'd100, 8'hF9, 1'b1, 0);
    applyStimulus(8'h80, 8'hFF, 1'b0, 0);
    applyStimulus(8'd55, 8'd0, 1'b0, 5);
    applyStimulus(8'd255, 8'd1, 1'b0, 0);
    applyStimulus(8'd0, 8'd5, 1'b0, 0);
    applyStimulus(8'd7, 8'd100, 1'b0, 0);
    applyStimulus(8'h80, 8'd1, 1'b1, 0);
    applyStimulus(8'd255, 8'd255, 1'b0, 0);
    applyReset();
    applyStimulus(8'd200, 8'd16, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      applyStimulus(a, b, 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
